axis_param_fifo: RTL and testbench

AXIS_PARAM_FIFO -- requirements
Module: axis_param_fifo

---
 rtl/axis_param_fifo.sv | 143 ++++++++++++++
 tb/tb_axis_param_fifo.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_param_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : axis_param_fifo
// Brief   : First-word-fall-through AXI4-Stream FIFO with level and threshold
//           flags. Define AXIS_FIFO_PKT_MODE_EN for store-and-forward packets.
// Rev     : 1.0  initial release
// ============================================================================
module axis_param_fifo #(
   parameter int DATA_W            = 32,
   parameter int DEPTH             = 512,
   parameter int PROG_EMPTY_THRESH = 64,
   parameter int PROG_FULL_THRESH  = 448
) (
   input  logic                      clk,
   input  logic                      resetn,
   input  logic [DATA_W-1:0]         s_axis_tdata,
   input  logic                      s_axis_tvalid,
   output logic                      s_axis_tready,
   input  logic                      s_axis_tlast,
   output logic [DATA_W-1:0]         m_axis_tdata,
   output logic                      m_axis_tvalid,
   input  logic                      m_axis_tready,
   output logic                      m_axis_tlast,
   output logic [$clog2(DEPTH):0]    axis_data_count,
   output logic                      prog_empty,
   output logic                      prog_full,
   output logic [$clog2(DEPTH):0]    axis_pkt_count
);

   localparam int              c_aw    = $clog2(DEPTH);
   localparam int              c_cw    = c_aw + 1;
   localparam logic [c_cw-1:0] c_depth = c_cw'(DEPTH);
   localparam logic [c_cw-1:0] c_pe    = c_cw'(PROG_EMPTY_THRESH);
   localparam logic [c_cw-1:0] c_pf    = c_cw'(PROG_FULL_THRESH);

   // Storage: tlast rides in the top bit next to the data word
   logic [DATA_W:0]   ram [DEPTH];

   logic [c_aw-1:0]   wr_ptr_q, wr_ptr_d;
   logic [c_aw-1:0]   rd_ptr_q, rd_ptr_d;
   logic [c_cw-1:0]   count_q,  count_d;
   logic              init_q,   init_d;

   logic              w_wr_en;
   logic              w_rd_en;

   // Ready is withheld until the first edge after reset release
   assign s_axis_tready   = init_q && (count_q < c_depth);
   assign w_wr_en         = s_axis_tvalid && s_axis_tready;
   assign w_rd_en         = m_axis_tvalid && m_axis_tready;

   assign {m_axis_tlast, m_axis_tdata} = ram[rd_ptr_q];

   assign axis_data_count = count_q;
   assign prog_empty      = (count_q <= c_pe);
   assign prog_full       = (count_q >= c_pf);

   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         ram[wr_ptr_q] <= {s_axis_tlast, s_axis_tdata};
      end
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      init_d   = 1'b1;
      if (w_wr_en) begin
         wr_ptr_d = wr_ptr_q + c_aw'(1);
      end
      if (w_rd_en) begin
         rd_ptr_d = rd_ptr_q + c_aw'(1);
      end
      case ({w_wr_en, w_rd_en})
         2'b10:   count_d = count_q + c_cw'(1);
         2'b01:   count_d = count_q - c_cw'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         init_q   <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         init_q   <= init_d;
      end
   end

`ifdef AXIS_FIFO_PKT_MODE_EN
   logic [c_cw-1:0]   pkt_q, pkt_d;
   logic              release_q, release_d;
   logic              w_pkt_in;
   logic              w_pkt_out;
   logic              w_starved;
   logic              w_cut_through;

   assign w_pkt_in      = w_wr_en && s_axis_tlast;
   assign w_pkt_out     = w_rd_en && m_axis_tlast;
   // A full FIFO holding no complete packet would never drain: open it up
   assign w_starved     = (count_q == c_depth) && (pkt_q == '0);
   assign w_cut_through = release_q || w_starved;
   assign m_axis_tvalid = (count_q != '0) && ((pkt_q != '0) || w_cut_through);
   assign axis_pkt_count = pkt_q;

   always_comb begin
      pkt_d     = pkt_q;
      release_d = release_q;
      case ({w_pkt_in, w_pkt_out})
         2'b10:   pkt_d = pkt_q + c_cw'(1);
         2'b01:   pkt_d = pkt_q - c_cw'(1);
         default: pkt_d = pkt_q;
      endcase
      if (w_pkt_out) begin
         release_d = 1'b0;
      end else if (w_starved) begin
         release_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         pkt_q     <= '0;
         release_q <= 1'b0;
      end else begin
         pkt_q     <= pkt_d;
         release_q <= release_d;
      end
   end
`else
   assign m_axis_tvalid  = (count_q != '0);
   assign axis_pkt_count = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_axis_param_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_axis_param_fifo
// Brief   : Self-checking bench for axis_param_fifo (DEPTH=16 configuration).
// Rev     : 1.0  initial release
// ============================================================================
module tb_axis_param_fifo;

   localparam int DW     = 32;
   localparam int DEPTH  = 16;
   localparam int PE     = 4;
   localparam int PF     = 12;
   localparam int NBEATS = 768;

   logic        clk = 1'b0;
   logic        resetn = 1'b1;
   logic [31:0] s_axis_tdata = '0;
   logic        s_axis_tvalid = 1'b0;
   logic        s_axis_tlast = 1'b0;
   logic        s_axis_tready;
   logic [31:0] m_axis_tdata;
   logic        m_axis_tvalid;
   logic        m_axis_tready = 1'b0;
   logic        m_axis_tlast;
   logic [4:0]  axis_data_count;
   logic [4:0]  axis_pkt_count;
   logic        prog_empty;
   logic        prog_full;

   int          errors = 0;
   int          checks = 0;
   logic [32:0] rx_q [$];
   bit          wr_hs;
   int          max_cnt = 0;

   always #5 clk = ~clk;

   axis_param_fifo #(
      .DATA_W            (DW),
      .DEPTH             (DEPTH),
      .PROG_EMPTY_THRESH (PE),
      .PROG_FULL_THRESH  (PF)
   ) dut (
      .clk             (clk),
      .resetn          (resetn),
      .s_axis_tdata    (s_axis_tdata),
      .s_axis_tvalid   (s_axis_tvalid),
      .s_axis_tready   (s_axis_tready),
      .s_axis_tlast    (s_axis_tlast),
      .m_axis_tdata    (m_axis_tdata),
      .m_axis_tvalid   (m_axis_tvalid),
      .m_axis_tready   (m_axis_tready),
      .m_axis_tlast    (m_axis_tlast),
      .axis_data_count (axis_data_count),
      .prog_empty      (prog_empty),
      .prog_full       (prog_full),
      .axis_pkt_count  (axis_pkt_count)
   );

   initial begin
      #1500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // One cycle: drive at negedge, observe handshakes, return at next negedge
   task automatic tick(input logic sv, input logic [31:0] sd, input logic sl, input logic mr);
      s_axis_tvalid = sv;
      s_axis_tdata  = sd;
      s_axis_tlast  = sl;
      m_axis_tready = mr;
      #1;
      wr_hs = s_axis_tvalid && s_axis_tready;
      if (m_axis_tvalid && m_axis_tready) rx_q.push_back({m_axis_tlast, m_axis_tdata});
      if (int'(axis_data_count) > max_cnt) max_cnt = int'(axis_data_count);
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic logic pick_last();
`ifdef AXIS_FIFO_PKT_MODE_EN
      return 1'b1;
`else
      return ($urandom_range(0, 1) == 1);
`endif
   endfunction

   task automatic test_reset();
      resetn = 1'b0;
      #100;
      checks++; if (s_axis_tready !== 1'b0) begin errors++; $display("FAIL rst_tready: got %b want 0", s_axis_tready); end
      checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid: got %b want 0", m_axis_tvalid); end
      checks++; if (axis_data_count !== 5'd0) begin errors++; $display("FAIL rst_count: got %0d want 0", axis_data_count); end
      checks++; if (axis_pkt_count !== 5'd0) begin errors++; $display("FAIL rst_pkt: got %0d want 0", axis_pkt_count); end
      checks++; if (prog_empty !== 1'b1) begin errors++; $display("FAIL rst_prog_empty: got %b want 1", prog_empty); end
      checks++; if (prog_full !== 1'b0) begin errors++; $display("FAIL rst_prog_full: got %b want 0", prog_full); end
      resetn = 1'b1;
      #1;
      checks++; if (s_axis_tready !== 1'b0) begin errors++; $display("FAIL rst_tready_pre_edge: got %b want 0", s_axis_tready); end
      @(posedge clk);
      #1;
      checks++; if (s_axis_tready !== 1'b1) begin errors++; $display("FAIL rst_tready_post_edge: got %b want 1", s_axis_tready); end
      @(negedge clk);
   endtask

   task automatic test_fill();
      int   n;
      logic e;
      rx_q.delete();
      s_axis_tvalid = 1'b1; s_axis_tdata = 32'd0; s_axis_tlast = 1'b1; m_axis_tready = 1'b0;
      #1;
      checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL fill_no_bypass: got %b want 0", m_axis_tvalid); end
      for (int i = 0; i < DEPTH; i++) begin
         tick(1'b1, 32'(i), 1'b1, 1'b0);
         n = i + 1;
         checks++; if (axis_data_count !== 5'(n)) begin errors++; $display("FAIL fill_count[%0d]: got %0d want %0d", i, axis_data_count, n); end
         e = (n <= PE);
         checks++; if (prog_empty !== e) begin errors++; $display("FAIL fill_prog_empty[%0d]: got %b want %b", i, prog_empty, e); end
         e = (n >= PF);
         checks++; if (prog_full !== e) begin errors++; $display("FAIL fill_prog_full[%0d]: got %b want %b", i, prog_full, e); end
         e = (n < DEPTH);
         checks++; if (s_axis_tready !== e) begin errors++; $display("FAIL fill_tready[%0d]: got %b want %b", i, s_axis_tready, e); end
         checks++; if (m_axis_tvalid !== 1'b1) begin errors++; $display("FAIL fill_tvalid[%0d]: got %b want 1", i, m_axis_tvalid); end
         checks++; if (m_axis_tdata !== 32'd0) begin errors++; $display("FAIL fill_head[%0d]: got %h want 0", i, m_axis_tdata); end
      end
      for (int i = 0; i < 3; i++) begin
         tick(1'b1, 32'd99, 1'b1, 1'b0);
         checks++; if (axis_data_count !== 5'd16) begin errors++; $display("FAIL fill_stall_count: got %0d want 16", axis_data_count); end
      end
      for (int i = 0; i < DEPTH; i++) tick(1'b0, 32'd0, 1'b0, 1'b1);
      checks++; if (rx_q.size() != DEPTH) begin errors++; $display("FAIL fill_rx_size: got %0d want %0d", rx_q.size(), DEPTH); end
      for (int k = 0; k < rx_q.size(); k++) begin
         checks++; if (rx_q[k] !== {1'b1, 32'(k)}) begin errors++; $display("FAIL fill_rx[%0d]: got %h want %h", k, rx_q[k], {1'b1, 32'(k)}); end
      end
      checks++; if (axis_data_count !== 5'd0) begin errors++; $display("FAIL fill_end_count: got %0d want 0", axis_data_count); end
      checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL fill_end_tvalid: got %b want 0", m_axis_tvalid); end
   endtask

   task automatic test_steady();
      logic [32:0] g [28];
      rx_q.delete();
      for (int k = 0; k < 28; k++) g[k] = {pick_last(), 32'($urandom())};
      for (int k = 0; k < 8; k++) tick(1'b1, g[k][31:0], g[k][32], 1'b0);
      checks++; if (axis_data_count !== 5'd8) begin errors++; $display("FAIL steady_prefill: got %0d want 8", axis_data_count); end
      for (int k = 0; k < 20; k++) begin
         tick(1'b1, g[8+k][31:0], g[8+k][32], 1'b1);
         checks++; if (axis_data_count !== 5'd8) begin errors++; $display("FAIL steady_count[%0d]: got %0d want 8", k, axis_data_count); end
      end
      for (int k = 0; k < 8; k++) tick(1'b0, 32'd0, 1'b0, 1'b1);
      checks++; if (rx_q.size() != 28) begin errors++; $display("FAIL steady_rx_size: got %0d want 28", rx_q.size()); end
      for (int k = 0; k < rx_q.size() && k < 28; k++) begin
         checks++; if (rx_q[k] !== g[k]) begin errors++; $display("FAIL steady_rx[%0d]: got %h want %h", k, rx_q[k], g[k]); end
      end
      checks++; if (axis_data_count !== 5'd0) begin errors++; $display("FAIL steady_end_count: got %0d want 0", axis_data_count); end
   endtask

   task automatic test_throttled_drain();
      logic [32:0] gen [NBEATS];
      int idx = 0;
      int cyc = 0;
      rx_q.delete();
      max_cnt = 0;
      for (int k = 0; k < NBEATS; k++) gen[k] = {pick_last(), 32'($urandom())};
      while (rx_q.size() < NBEATS && cyc < 85000) begin
         if (idx < NBEATS) tick(1'b1, gen[idx][31:0], gen[idx][32], (cyc % 101) == 0);
         else              tick(1'b0, 32'd0, 1'b0, (cyc % 101) == 0);
         if (wr_hs) idx++;
         cyc++;
      end
      checks++; if (rx_q.size() != NBEATS) begin errors++; $display("FAIL drain_timeout: received %0d want %0d", rx_q.size(), NBEATS); end
      checks++; if (idx != NBEATS) begin errors++; $display("FAIL drain_sent: got %0d want %0d", idx, NBEATS); end
      for (int k = 0; k < rx_q.size() && k < NBEATS; k++) begin
         checks++; if (rx_q[k] !== gen[k]) begin errors++; $display("FAIL drain_rx[%0d]: got %h want %h", k, rx_q[k], gen[k]); end
      end
      checks++; if (max_cnt > DEPTH) begin errors++; $display("FAIL drain_max_count: got %0d want <= %0d", max_cnt, DEPTH); end
      checks++; if (axis_data_count !== 5'd0) begin errors++; $display("FAIL drain_end_count: got %0d want 0", axis_data_count); end
      checks++; if (prog_empty !== 1'b1) begin errors++; $display("FAIL drain_end_prog_empty: got %b want 1", prog_empty); end
      checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL drain_end_tvalid: got %b want 0", m_axis_tvalid); end
   endtask

   task automatic test_midreset();
      for (int k = 0; k < 10; k++) tick(1'b1, 32'hDEAD_0000 + 32'(k), 1'b1, 1'b0);
      checks++; if (axis_data_count !== 5'd10) begin errors++; $display("FAIL mid_prefill: got %0d want 10", axis_data_count); end
      s_axis_tvalid = 1'b0;
      #2;
      resetn = 1'b0;
      #1;
      checks++; if (axis_data_count !== 5'd0) begin errors++; $display("FAIL mid_async_count: got %0d want 0", axis_data_count); end
      checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL mid_async_tvalid: got %b want 0", m_axis_tvalid); end
      checks++; if (s_axis_tready !== 1'b0) begin errors++; $display("FAIL mid_async_tready: got %b want 0", s_axis_tready); end
      checks++; if (prog_empty !== 1'b1) begin errors++; $display("FAIL mid_async_prog_empty: got %b want 1", prog_empty); end
      @(negedge clk);
      @(negedge clk);
      resetn = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rx_q.delete();
      for (int k = 0; k < 3; k++) tick(1'b1, 32'hA5A5_0000 + 32'(k), k == 2, 1'b0);
      checks++; if (axis_data_count !== 5'd3) begin errors++; $display("FAIL mid_refill: got %0d want 3", axis_data_count); end
      for (int k = 0; k < 3; k++) tick(1'b0, 32'd0, 1'b0, 1'b1);
      checks++; if (rx_q.size() != 3) begin errors++; $display("FAIL mid_rx_size: got %0d want 3", rx_q.size()); end
      for (int k = 0; k < rx_q.size() && k < 3; k++) begin
         checks++; if (rx_q[k] !== {k == 2, 32'hA5A5_0000 + 32'(k)}) begin errors++; $display("FAIL mid_rx[%0d]: got %h want %h", k, rx_q[k], {k == 2, 32'hA5A5_0000 + 32'(k)}); end
      end
      checks++; if (axis_data_count !== 5'd0) begin errors++; $display("FAIL mid_end_count: got %0d want 0", axis_data_count); end
   endtask

`ifdef AXIS_FIFO_PKT_MODE_EN
   task automatic test_packet();
      logic [31:0] d [4];
      rx_q.delete();
      for (int k = 0; k < 4; k++) d[k] = $urandom();
      for (int k = 0; k < 3; k++) begin
         tick(1'b1, d[k], 1'b0, 1'b1);
         checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL pkt_hold_write[%0d]: got %b want 0", k, m_axis_tvalid); end
      end
      for (int k = 0; k < 10; k++) begin
         tick(1'b0, 32'd0, 1'b0, 1'b1);
         checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL pkt_hold_idle[%0d]: got %b want 0", k, m_axis_tvalid); end
      end
      checks++; if (axis_pkt_count !== 5'd0) begin errors++; $display("FAIL pkt_count_before: got %0d want 0", axis_pkt_count); end
      tick(1'b1, d[3], 1'b1, 1'b1);
      checks++; if (m_axis_tvalid !== 1'b1) begin errors++; $display("FAIL pkt_release_tvalid: got %b want 1", m_axis_tvalid); end
      checks++; if (axis_pkt_count !== 5'd1) begin errors++; $display("FAIL pkt_count_one: got %0d want 1", axis_pkt_count); end
      for (int k = 0; k < 4; k++) tick(1'b0, 32'd0, 1'b0, 1'b1);
      checks++; if (axis_pkt_count !== 5'd0) begin errors++; $display("FAIL pkt_count_after: got %0d want 0", axis_pkt_count); end
      checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL pkt_tvalid_after: got %b want 0", m_axis_tvalid); end
      checks++; if (rx_q.size() != 4) begin errors++; $display("FAIL pkt_rx_size: got %0d want 4", rx_q.size()); end
      for (int k = 0; k < rx_q.size() && k < 4; k++) begin
         checks++; if (rx_q[k] !== {k == 3, d[k]}) begin errors++; $display("FAIL pkt_rx[%0d]: got %h want %h", k, rx_q[k], {k == 3, d[k]}); end
      end
      rx_q.delete();
      for (int k = 0; k < DEPTH; k++) begin
         tick(1'b1, 32'hC000_0000 + 32'(k), 1'b0, 1'b0);
         checks++; if (m_axis_tvalid !== (k == DEPTH - 1)) begin errors++; $display("FAIL cut_tvalid[%0d]: got %b want %b", k, m_axis_tvalid, k == DEPTH - 1); end
      end
      for (int k = 0; k < DEPTH; k++) tick(1'b0, 32'd0, 1'b0, 1'b1);
      checks++; if (rx_q.size() != DEPTH) begin errors++; $display("FAIL cut_rx_size: got %0d want %0d", rx_q.size(), DEPTH); end
      for (int k = 0; k < rx_q.size() && k < DEPTH; k++) begin
         checks++; if (rx_q[k] !== {1'b0, 32'hC000_0000 + 32'(k)}) begin errors++; $display("FAIL cut_rx[%0d]: got %h", k, rx_q[k]); end
      end
      tick(1'b1, 32'h0000_00E0, 1'b1, 1'b0);
      checks++; if (axis_pkt_count !== 5'd1) begin errors++; $display("FAIL cut_tail_pkt: got %0d want 1", axis_pkt_count); end
      tick(1'b0, 32'd0, 1'b0, 1'b1);
      checks++; if (axis_pkt_count !== 5'd0) begin errors++; $display("FAIL cut_tail_pkt_after: got %0d want 0", axis_pkt_count); end
      tick(1'b1, 32'h0000_00F0, 1'b0, 1'b0);
      checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL cut_closed_tvalid: got %b want 0", m_axis_tvalid); end
   endtask
`else
   task automatic test_no_packet();
      logic [31:0] d0, d1;
      rx_q.delete();
      d0 = $urandom();
      d1 = $urandom();
      tick(1'b1, d0, 1'b0, 1'b0);
      checks++; if (m_axis_tvalid !== 1'b1) begin errors++; $display("FAIL word_tvalid: got %b want 1", m_axis_tvalid); end
      checks++; if (axis_pkt_count !== 5'd0) begin errors++; $display("FAIL word_pkt0: got %0d want 0", axis_pkt_count); end
      tick(1'b1, d1, 1'b1, 1'b0);
      checks++; if (axis_pkt_count !== 5'd0) begin errors++; $display("FAIL word_pkt1: got %0d want 0", axis_pkt_count); end
      tick(1'b0, 32'd0, 1'b0, 1'b1);
      tick(1'b0, 32'd0, 1'b0, 1'b1);
      checks++; if (rx_q.size() != 2) begin errors++; $display("FAIL word_rx_size: got %0d want 2", rx_q.size()); end
      if (rx_q.size() == 2) begin
         checks++; if (rx_q[0] !== {1'b0, d0}) begin errors++; $display("FAIL word_rx0: got %h want %h", rx_q[0], {1'b0, d0}); end
         checks++; if (rx_q[1] !== {1'b1, d1}) begin errors++; $display("FAIL word_rx1: got %h want %h", rx_q[1], {1'b1, d1}); end
      end
      checks++; if (axis_data_count !== 5'd0) begin errors++; $display("FAIL word_end_count: got %0d want 0", axis_data_count); end
   endtask
`endif

   initial begin
      test_reset();
      test_fill();
      test_steady();
      test_throttled_drain();
      test_midreset();
`ifdef AXIS_FIFO_PKT_MODE_EN
      test_packet();
`else
      test_no_packet();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
